// File: rtl/averager_ctrl.sv
// Control FSM for a BRAM-based frame averager: accumulate P passes, then read out.
// Optional sticky overrun flag: define AVERAGER_CTRL_OVERRUN_EN.
module averager_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 16,
    parameter int AVERAGES_WIDTH  = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       cfg_start,
    input  logic [BRAM_ADDR_WIDTH-1:0] cfg_frame_len,
    input  logic [AVERAGES_WIDTH-1:0]  cfg_averages,
    input  logic                       trig,
    input  logic                       S_AXIS_tvalid,
    output logic                       S_AXIS_tready,
    output logic                       M_AXIS_tvalid,
    output logic                       M_AXIS_tlast,
    input  logic                       M_AXIS_tready,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr,
    output logic                       bram_we,
    output logic                       acc_first,
    output logic                       busy,
    output logic                       done,
    output logic [AVERAGES_WIDTH-1:0]  pass_count
`ifdef AVERAGER_CTRL_OVERRUN_EN
    ,
    output logic                       overrun
`endif
);

    localparam logic [BRAM_ADDR_WIDTH-1:0] ONE_A = 1;
    localparam logic [AVERAGES_WIDTH-1:0]  ONE_P = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACCUM,
        S_READOUT,
        S_DONE
    } state_t;

    state_t                     state;
    logic [BRAM_ADDR_WIDTH-1:0] frame_len;
    logic [AVERAGES_WIDTH-1:0]  averages;
    logic [BRAM_ADDR_WIDTH-1:0] idx;
    logic                       s_fire;
    logic                       m_fire;
    logic                       start_ok;
    logic                       last_sample;
    logic                       last_pass;

    assign s_fire      = S_AXIS_tvalid & S_AXIS_tready;
    assign m_fire      = M_AXIS_tvalid & M_AXIS_tready;
    assign start_ok    = (state == S_IDLE) && cfg_start && (cfg_frame_len != '0);
    assign last_sample = (idx == frame_len - ONE_A);
    assign last_pass   = (pass_count + ONE_P == averages);

    // Read address runs one word ahead on a readout beat so the next word is ready
    assign bram_rd_addr = idx + (m_fire ? ONE_A : '0);

    // Main sequencer: run setup, per-sample accumulate, and readout beats
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= S_IDLE;
            frame_len     <= '0;
            averages      <= '0;
            idx           <= '0;
            S_AXIS_tready <= 1'b0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            bram_wr_addr  <= '0;
            bram_we       <= 1'b0;
            acc_first     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass_count    <= '0;
        end else begin
            bram_we <= s_fire;
            done    <= 1'b0;
            if (s_fire) begin
                bram_wr_addr <= idx;
            end
            unique case (state)
                S_IDLE: begin
                    acc_first <= 1'b0;
                    if (start_ok) begin
                        frame_len  <= cfg_frame_len;
                        averages   <= (cfg_averages == '0) ? ONE_P : cfg_averages;
                        pass_count <= '0;
                        idx        <= '0;
                        acc_first  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ARM;
                    end
                end
                S_ARM: begin
                    acc_first <= (pass_count == '0);
                    if (trig) begin
                        S_AXIS_tready <= 1'b1;
                        idx           <= '0;
                        state         <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // One cycle late, so it lines up with the write of the fired sample
                    acc_first <= (pass_count == '0);
                    if (s_fire) begin
                        if (last_sample) begin
                            idx           <= '0;
                            S_AXIS_tready <= 1'b0;
                            pass_count    <= pass_count + ONE_P;
                            state         <= last_pass ? S_READOUT : S_ARM;
                        end else begin
                            idx <= idx + ONE_A;
                        end
                    end
                end
                S_READOUT: begin
                    acc_first <= 1'b0;
                    if (!M_AXIS_tvalid) begin
                        M_AXIS_tvalid <= 1'b1;
                        M_AXIS_tlast  <= last_sample;
                    end else if (m_fire) begin
                        if (M_AXIS_tlast) begin
                            M_AXIS_tvalid <= 1'b0;
                            M_AXIS_tlast  <= 1'b0;
                            idx           <= '0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            idx          <= idx + ONE_A;
                            M_AXIS_tlast <= (idx + ONE_A == frame_len - ONE_A);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AVERAGER_CTRL_OVERRUN_EN
    // Sticky flag: samples offered while the controller cannot accept them
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            overrun <= 1'b0;
        end else if (start_ok) begin
            overrun <= 1'b0;
        end else if (S_AXIS_tvalid && (state == S_ARM || state == S_READOUT)) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
